// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter in front of the AHB-to-APB bridge slave port.
// Grants the address phase to one master at a time, tracks the data-phase
// owner, muxes address/control/write data, honours locked transfers and
// bounds each master's tenure when other masters are waiting.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_TENURE  = 8,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    input  logic [NUM_MASTERS-1:0]    hbusreq,
    input  logic [NUM_MASTERS-1:0]    hlock,
    input  logic [2*NUM_MASTERS-1:0]  htrans_m,
    input  logic [32*NUM_MASTERS-1:0] haddr_m,
    input  logic [NUM_MASTERS-1:0]    hwrite_m,
    input  logic [32*NUM_MASTERS-1:0] hwdata_m,
    input  logic                      hreadyin,
    output logic [NUM_MASTERS-1:0]    hgrant,
    output logic [MW-1:0]             hmaster,
    output logic [MW-1:0]             hmaster_data,
    output logic                      hmastlock,
    output logic [1:0]                htrans,
    output logic [31:0]               haddr,
    output logic                      hwrite,
    output logic [31:0]               hwdata
);

    // Arbiter FSM states
    localparam logic [1:0] ST_PARK   = 2'd0;  // owner not requesting
    localparam logic [1:0] ST_OWNED  = 2'd1;  // owner requesting, unlocked
    localparam logic [1:0] ST_LOCKED = 2'd2;  // owner holds a locked sequence

    // HTRANS encodings that matter to arbitration
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [7:0] TENURE_LIMIT = 8'(MAX_TENURE);

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [7:0]             tcnt;
    logic                   owner_req;
    logic                   owner_lock;
    logic                   other_req;
    logic                   accepted;
    logic                   handover_ok;
    logic                   do_switch;
    logic [MW-1:0]          next_owner;
    logic [NUM_MASTERS-1:0] owner_onehot;

    function automatic logic [NUM_MASTERS-1:0] to_onehot(input logic [MW-1:0] idx);
        logic [NUM_MASTERS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (MW'(i) == idx) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Address-phase mux on hmaster, write-data mux on hmaster_data
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        htrans     = '0;
        haddr      = '0;
        hwrite     = 1'b0;
        hwdata     = '0;
        owner_req  = 1'b0;
        owner_lock = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (MW'(i) == hmaster) begin
                htrans     = htrans_m[2*i +: 2];
                haddr      = haddr_m[32*i +: 32];
                hwrite     = hwrite_m[i];
                owner_req  = hbusreq[i];
                owner_lock = hlock[i];
            end
            if (MW'(i) == hmaster_data) begin
                hwdata = hwdata_m[32*i +: 32];
            end
        end
    end

    // Round-robin search starting after the current owner; owner comes last
    always_comb begin
        int idx;
        logic found;
        idx        = 0;
        found      = 1'b0;
        next_owner = hmaster;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(hmaster) + k) % NUM_MASTERS;
            if (!found && hbusreq[idx]) begin
                next_owner = MW'(idx);
                found      = 1'b1;
            end
        end
    end

    // Switch decision and next FSM state when the owner keeps the bus
    always_comb begin
        owner_onehot = to_onehot(hmaster);
        other_req    = |(hbusreq & ~owner_onehot);
        accepted     = (htrans == TR_NONSEQ) || (htrans == TR_SEQ);
        handover_ok  = (state != ST_LOCKED) &&
                       ((htrans == TR_IDLE) || (htrans == TR_NONSEQ));
        do_switch    = handover_ok && other_req &&
                       (!owner_req || (tcnt >= TENURE_LIMIT));
        state_nxt    = ST_PARK;
        if (state == ST_LOCKED && owner_lock) begin
            state_nxt = ST_LOCKED;
        end else if (state != ST_LOCKED && owner_req && owner_lock) begin
            state_nxt = ST_LOCKED;
        end else if (owner_req) begin
            state_nxt = ST_OWNED;
        end
    end

    // Ownership, tenure and lock registers; frozen while the bridge stalls
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hgrant       <= to_onehot('0);
            hmaster      <= '0;
            hmaster_data <= '0;
            hmastlock    <= 1'b0;
            tcnt         <= '0;
            state        <= ST_PARK;
        end else if (hreadyin) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values, independent of statement order.
            hmaster_data <= hmaster;
            if (do_switch) begin
                hgrant    <= to_onehot(next_owner);
                hmaster   <= next_owner;
                tcnt      <= '0;
                state     <= ST_OWNED;
                hmastlock <= 1'b0;
            end else begin
                if (accepted && (tcnt < TENURE_LIMIT)) begin
                    tcnt <= tcnt + 8'd1;
                end
                state     <= state_nxt;
                hmastlock <= (state_nxt == ST_LOCKED);
            end
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed self-checking bench for ahb_bus_arbiter (4 masters, tenure of 4).
module tb_ahb_bus_arbiter;

    localparam int NM = 4;

    logic            hclk;
    logic            hresetn;
    logic [NM-1:0]   hbusreq;
    logic [NM-1:0]   hlock;
    logic [2*NM-1:0] htrans_m;
    logic [32*NM-1:0] haddr_m;
    logic [NM-1:0]   hwrite_m;
    logic [32*NM-1:0] hwdata_m;
    logic            hreadyin;
    logic [NM-1:0]   hgrant;
    logic [1:0]      hmaster;
    logic [1:0]      hmaster_data;
    logic            hmastlock;
    logic [1:0]      htrans;
    logic [31:0]     haddr;
    logic            hwrite;
    logic [31:0]     hwdata;

    int checks = 0;
    int errors = 0;

    ahb_bus_arbiter #(.NUM_MASTERS(NM), .MAX_TENURE(4)) dut (
        .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hlock(hlock),
        .htrans_m(htrans_m), .haddr_m(haddr_m), .hwrite_m(hwrite_m),
        .hwdata_m(hwdata_m), .hreadyin(hreadyin), .hgrant(hgrant),
        .hmaster(hmaster), .hmaster_data(hmaster_data), .hmastlock(hmastlock),
        .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_trans(input int m, input logic [1:0] t);
        htrans_m[2*m +: 2] = t;
    endtask

    task automatic pulse_reset();
        hresetn = 1'b0;
        tick();
        hresetn = 1'b1;
    endtask

    localparam logic [31:0] A0 = 32'h1111_1000, A1 = 32'h2222_2000;
    localparam logic [31:0] A2 = 32'h3333_3000, A3 = 32'h4444_4000;
    localparam logic [31:0] D0 = 32'hDDDD_0000, D1 = 32'hDDDD_0001;
    localparam logic [31:0] D2 = 32'hDDDD_0002, D3 = 32'hDDDD_0003;

    initial begin
        int exp_m [10];
        int exp_d [10];
        exp_m = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
        exp_d = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};

        hresetn  = 1'b0;
        hbusreq  = '0;
        hlock    = '0;
        htrans_m = '0;
        haddr_m  = {A3, A2, A1, A0};
        hwrite_m = 4'b1010;
        hwdata_m = {D3, D2, D1, D0};
        hreadyin = 1'b1;

        // Reset values
        tick();
        tick();
        check("rst_hgrant", 32'(hgrant), 32'h1);
        check("rst_hmaster", 32'(hmaster), 32'd0);
        check("rst_hmaster_data", 32'(hmaster_data), 32'd0);
        check("rst_hmastlock", 32'(hmastlock), 32'd0);
        check("rst_haddr", haddr, A0);
        hresetn = 1'b1;

        // Master 2 requests from park on master 0
        hbusreq = 4'b0100;
        set_trans(2, 2'b10);
        tick();
        check("m2_hgrant", 32'(hgrant), 32'h4);
        check("m2_hmaster", 32'(hmaster), 32'd2);
        check("m2_haddr", haddr, A2);
        check("m2_hmaster_data_lag", 32'(hmaster_data), 32'd0);
        tick();
        check("m2_hmaster_data", 32'(hmaster_data), 32'd2);

        // Masters 0 and 1 contend with NONSEQ every cycle
        pulse_reset();
        hbusreq  = 4'b0011;
        htrans_m = '0;
        set_trans(0, 2'b10);
        set_trans(1, 2'b10);
        for (int e = 0; e < 10; e++) begin
            tick();
            check($sformatf("rr_hmaster_e%0d", e + 1), 32'(hmaster), 32'(exp_m[e]));
            check($sformatf("rr_hmaster_data_e%0d", e + 1), 32'(hmaster_data), 32'(exp_d[e]));
        end

        // Owner 1 in SEQ with stalls while master 3 waits on an expired tenure
        pulse_reset();
        hbusreq  = 4'b0010;
        htrans_m = '0;
        set_trans(1, 2'b10);
        tick();
        check("seq_first_owner", 32'(hmaster), 32'd1);
        repeat (4) tick();
        hbusreq = 4'b1010;
        set_trans(1, 2'b11);
        set_trans(3, 2'b10);
        hreadyin = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check($sformatf("stall_hgrant_%0d", s), 32'(hgrant), 32'h2);
            check($sformatf("stall_hwdata_%0d", s), hwdata, D1);
        end
        hreadyin = 1'b1;
        tick();
        check("seq_ready_hmaster", 32'(hmaster), 32'd1);
        check("seq_ready_hwdata", hwdata, D1);
        set_trans(1, 2'b00);
        tick();
        check("handover_hgrant", 32'(hgrant), 32'h8);
        check("handover_haddr", haddr, A3);
        check("handover_hwdata_old", hwdata, D1);
        tick();
        check("handover_hwdata_new", hwdata, D3);

        // No requests: park on 3, then 3 re-requests
        hbusreq  = 4'b0000;
        htrans_m = '0;
        tick();
        tick();
        check("park_hgrant", 32'(hgrant), 32'h8);
        hbusreq = 4'b1000;
        set_trans(3, 2'b10);
        tick();
        check("rerequest_hmaster", 32'(hmaster), 32'd3);
        check("rerequest_hgrant", 32'(hgrant), 32'h8);

        // Locked tenure of master 0 with master 1 waiting
        pulse_reset();
        hbusreq  = 4'b0011;
        hlock    = 4'b0001;
        htrans_m = '0;
        set_trans(0, 2'b10);
        set_trans(1, 2'b10);
        for (int t = 0; t < 20; t++) begin
            tick();
            check($sformatf("lock_hmaster_t%0d", t), 32'(hmaster), 32'd0);
            check($sformatf("lock_hmastlock_t%0d", t), 32'(hmastlock), 32'd1);
        end
        hlock = 4'b0000;
        tick();
        check("unlock_hmaster", 32'(hmaster), 32'd0);
        check("unlock_hmastlock", 32'(hmastlock), 32'd0);
        tick();
        check("unlock_switch_hgrant", 32'(hgrant), 32'h2);

        // Async reset mid-tenure of a locked master 2
        hbusreq  = 4'b0100;
        hlock    = 4'b0100;
        htrans_m = '0;
        set_trans(2, 2'b10);
        tick();
        tick();
        check("pre_rst_hmaster", 32'(hmaster), 32'd2);
        check("pre_rst_hmastlock", 32'(hmastlock), 32'd1);
        #2;
        hresetn = 1'b0;
        #1;
        check("async_rst_hgrant", 32'(hgrant), 32'h1);
        check("async_rst_hmaster", 32'(hmaster), 32'd0);
        check("async_rst_hmastlock", 32'(hmastlock), 32'd0);
        check("async_rst_haddr", haddr, A0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
